// File: rtl/image_pkg.sv
// image_pkg: shared state encoding and default geometry for the image pipeline.
package image_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CONV  = 3'd1,
      POOL  = 3'd2,
      SQZ   = 3'd3,
      SQGAP = 3'd4,
      DONE  = 3'd5
   } state_t;
   localparam int CONV1_OUT_DIM = 111;
   localparam int POOL_OUT_DIM  = 55;
   localparam int NUM_FIRES     = 8;
endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: valid strobes in, stage enables/addresses/status out.
interface layer_sequencer_if #(parameter int CNT_W = 32);
   logic             start;
   logic             conv1_valid;
   logic             pool_valid;
   logic             sq_valid;
   logic             conv1_en;
   logic             pool_en;
   logic             sq_en;
   logic [CNT_W-1:0] conv_addr;
   logic [CNT_W-1:0] pool_addr;
   logic [2:0]       firesel;
   logic             pp_bank;
   logic             busy;
   logic             done;
   logic [2:0]       state;
   modport master (
      input  start, conv1_valid, pool_valid, sq_valid,
      output conv1_en, pool_en, sq_en, conv_addr, pool_addr, firesel, pp_bank, busy, done, state
   );
   modport slave (
      output start, conv1_valid, pool_valid, sq_valid,
      input  conv1_en, pool_en, sq_en, conv_addr, pool_addr, firesel, pp_bank, busy, done, state
   );
endinterface

// File: rtl/stage_counter.sv
// stage_counter: clearable up-counter whose last flag marks the increment reaching LIMIT.
module stage_counter #(
   parameter int          CNT_W = 32,
   parameter int unsigned LIMIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);
   assign last = inc && (count + CNT_W'(1) == CNT_W'(LIMIT));
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (inc)   count <= count + CNT_W'(1);
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps conv1 -> pool -> squeeze per fire, generating write addresses
// from each stage's valid strobes and flipping the ping-pong bank between fires.
module layer_sequencer #(
   parameter int CONV1_OUTS = image_pkg::CONV1_OUT_DIM * image_pkg::CONV1_OUT_DIM,
   parameter int POOL_OUTS  = image_pkg::POOL_OUT_DIM * image_pkg::POOL_OUT_DIM,
   parameter int SQ_OUTS    = image_pkg::POOL_OUT_DIM * image_pkg::POOL_OUT_DIM,
   parameter int NUM_FIRES  = image_pkg::NUM_FIRES,
   parameter int CNT_W      = 32
) (
   input logic               clk,
   input logic               rst,
   layer_sequencer_if.master bus
);
   import image_pkg::*;
   state_t           state, nxt;
   logic             conv_last, pool_last, sq_last;
   logic             start_img;
   logic [2:0]       fire;
   logic             bank;
   logic [CNT_W-1:0] sq_cnt;
   assign start_img = (state == IDLE) && bus.start;
   stage_counter #(.CNT_W(CNT_W), .LIMIT(CONV1_OUTS)) u_conv (
      .clk(clk), .rst(rst), .clr(start_img), .inc(state == CONV && bus.conv1_valid),
      .count(bus.conv_addr), .last(conv_last)
   );
   stage_counter #(.CNT_W(CNT_W), .LIMIT(POOL_OUTS)) u_pool (
      .clk(clk), .rst(rst), .clr(start_img), .inc(state == POOL && bus.pool_valid),
      .count(bus.pool_addr), .last(pool_last)
   );
   stage_counter #(.CNT_W(CNT_W), .LIMIT(SQ_OUTS)) u_sq (
      .clk(clk), .rst(rst), .clr(start_img || state == SQGAP), .inc(state == SQZ && bus.sq_valid),
      .count(sq_cnt), .last(sq_last)
   );
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.start ? CONV : IDLE;
         CONV:    nxt = conv_last ? POOL : CONV;
         POOL:    nxt = pool_last ? SQZ : POOL;
         SQZ:     nxt = !sq_last ? SQZ : (fire == 3'(NUM_FIRES - 1)) ? DONE : SQGAP;
         SQGAP:   nxt = SQZ;
         default: nxt = IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clk)
      if (rst) begin
         state        <= IDLE;
         bus.conv1_en <= 1'b0;
         bus.pool_en  <= 1'b0;
         bus.sq_en    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         fire         <= '0;
         bank         <= 1'b0;
      end else begin
         state        <= nxt;
         bus.conv1_en <= nxt == CONV;
         bus.pool_en  <= nxt == POOL;
         bus.sq_en    <= nxt == SQZ;
         bus.busy     <= nxt != IDLE;
         bus.done     <= nxt == DONE;
         fire         <= start_img ? 3'd0 : (state == SQGAP) ? fire + 3'd1 : fire;
         bank         <= start_img ? 1'b0 : (state == SQGAP) ? ~bank : bank;
      end
   assign bus.state   = state;
   assign bus.firesel = fire;
   assign bus.pp_bank = bank;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized stimulus checked each cycle against a stage-queue model.
module tb_layer_sequencer;
   localparam int C  = 4;
   localparam int P  = 2;
   localparam int S  = 3;
   localparam int NF = 2;
   localparam int W  = 32;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   layer_sequencer_if #(.CNT_W(W)) bus ();
   layer_sequencer #(
      .CONV1_OUTS(C), .POOL_OUTS(P), .SQ_OUTS(S), .NUM_FIRES(NF), .CNT_W(W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   int n_cmp = 0;
   int n_bad = 0;
   int tcyc  = 0;
   int nd    = 0;
   // model: an image is a queue of stage codes popped as each stage completes
   int q[$];
   int m_conv = 0, m_pool = 0, m_sq = 0, m_fire = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, tcyc);
      end
   endtask
   function automatic int mst();
      return (q.size() != 0) ? q[0] : 0;
   endfunction
   task automatic model_step(input bit r, input bit s, input bit cv, input bit pv, input bit sv);
      if (r) begin
         q.delete();
         m_conv = 0; m_pool = 0; m_sq = 0; m_fire = 0;
      end else if (q.size() == 0) begin
         if (s) begin
            q = {1, 2};
            for (int f = 0; f < NF; f++) begin
               q.push_back(3);
               q.push_back(f == NF - 1 ? 5 : 4);
            end
            m_conv = 0; m_pool = 0; m_sq = 0; m_fire = 0;
         end
      end else begin
         case (q[0])
            1: if (cv) begin m_conv++; if (m_conv == C) void'(q.pop_front()); end
            2: if (pv) begin m_pool++; if (m_pool == P) void'(q.pop_front()); end
            3: if (sv) begin m_sq++; if (m_sq == S) void'(q.pop_front()); end
            4: begin m_fire++; m_sq = 0; void'(q.pop_front()); end
            default: void'(q.pop_front());
         endcase
      end
   endtask
   task automatic step(input bit r, input bit s, input bit cv, input bit pv, input bit sv);
      int e;
      rst = r;
      bus.start = s;
      bus.conv1_valid = cv;
      bus.pool_valid = pv;
      bus.sq_valid = sv;
      @(posedge clk);
      model_step(r, s, cv, pv, sv);
      tcyc++;
      #1;
      e = mst();
      check("state", 64'(bus.state), 64'(e));
      check("enables", 64'({bus.conv1_en, bus.pool_en, bus.sq_en}), 64'({e == 1, e == 2, e == 3}));
      check("conv_addr", 64'(bus.conv_addr), 64'(m_conv));
      check("pool_addr", 64'(bus.pool_addr), 64'(m_pool));
      check("fire_bank", 64'({bus.firesel, bus.pp_bank}), 64'({m_fire[2:0], m_fire[0]}));
      check("busy_done", 64'({bus.busy, bus.done}), 64'({e != 0, e == 5}));
      if (bus.done === 1'b1) nd++;
      @(negedge clk);
   endtask
   // mode 0 continuous (+start while busy), 1 gapped conv valids, 2 stray strobes, 3 random
   task automatic run_image(input int mode, input bit rst_fire1);
      int budget;
      int e;
      bit s, cv, pv, sv, r;
      nd = 0;
      step(0, 1, 0, 0, 0);
      budget = 0;
      while (q.size() != 0 && budget < 3000) begin
         e = mst();
         s = 0; r = 0;
         cv = e == 1; pv = e == 2; sv = e == 3;
         case (mode)
            0: s = e == 2;
            1: cv = (tcyc % 3) == 0;
            2: begin pv = 1; sv = 1; end
            default: begin
               cv = 1'($urandom_range(0, 1));
               pv = 1'($urandom_range(0, 1));
               sv = 1'($urandom_range(0, 1));
               s  = $urandom_range(0, 3) == 0;
            end
         endcase
         if (rst_fire1 && e == 3 && m_fire == 1) r = 1;
         step(r, s, cv, pv, sv);
         budget++;
      end
      check("terminated", 64'(q.size()), 64'd0);
      check("done_pulses", 64'(nd), rst_fire1 ? 64'd0 : 64'd1);
   endtask
   initial begin
      repeat (3) step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1);
      repeat (3) step(0, 0, 0, 0, 0);
      run_image(0, 0);
      run_image(1, 0);
      run_image(2, 0);
      run_image(0, 1);
      run_image(0, 0);
      repeat (20) run_image(3, 0);
      repeat (2) step(0, 0, 1, 1, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
